// File: rtl/prco_fetch.sv
// prco_fetch: single-outstanding instruction fetch FSM between local memory and decode.
// Optional HALT-word detection is built when PRCO_FETCH_HALT_EN is defined.
//   state  | meaning
//   S_REQ  | issue fetch at PC when memory port is free
//   S_WAIT | request outstanding, capture word on i_ce_dec
//   S_DROP | request outstanding after a branch, discard its word
//   S_HOLD | q_instr valid, waiting for decode to accept
//   S_HALT | HALT word consumed, fetch stopped until reset
module prco_fetch #(
   parameter logic [15:0] P_RESET_PC = 16'h0000,
   parameter logic [15:0] P_PC_MAX   = 16'h00FF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_mem_busy,
   input  logic        i_ce_dec,
   input  logic [15:0] i_mem_douta,
   input  logic        i_dec_ready,
   input  logic        i_branch_en,
   input  logic [15:0] i_branch_addr,
   output logic        q_ce_fetch,
   output logic [15:0] q_mem_addr,
   output logic [15:0] q_instr,
   output logic [15:0] q_instr_pc,
   output logic        q_instr_valid,
   output logic        q_halted
);

   typedef enum logic [2:0] {S_REQ, S_WAIT, S_DROP, S_HOLD, S_HALT} t_state;

   t_state      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt, w_pc_inc;
   logic [15:0] r_instr, w_instr_nxt;
   logic [15:0] r_instr_pc, w_instr_pc_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_halt_pend, w_halt_pend_nxt;
   logic        w_ce_fetch;
   logic        w_is_halt;

`ifdef PRCO_FETCH_HALT_EN
   assign w_is_halt = (i_mem_douta == 16'hFFFF);
   assign q_halted  = (r_state == S_HALT);
`else
   assign w_is_halt = 1'b0;
   assign q_halted  = 1'b0;
`endif

   assign w_pc_inc = (r_pc == P_PC_MAX) ? 16'h0000 : r_pc + 16'd1;

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instr;
      w_instr_pc_nxt  = r_instr_pc;
      w_valid_nxt     = r_valid;
      w_halt_pend_nxt = r_halt_pend;
      w_ce_fetch      = 1'b0;
      case (r_state)
         S_REQ: begin
            // A branch suppresses the request so no stale-PC fetch is left in flight.
            if (i_branch_en) begin
               w_pc_nxt    = i_branch_addr;
               w_valid_nxt = 1'b0;
            end else if (!i_mem_busy && !i_reset) begin
               w_ce_fetch  = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_branch_en) begin
               w_pc_nxt    = i_branch_addr;
               w_valid_nxt = 1'b0;
               w_state_nxt = i_ce_dec ? S_REQ : S_DROP;
            end else if (i_ce_dec) begin
               w_instr_nxt    = i_mem_douta;
               w_instr_pc_nxt = r_pc;
               w_valid_nxt    = 1'b1;
               w_state_nxt    = S_HOLD;
               if (w_is_halt) w_halt_pend_nxt = 1'b1;
               else           w_pc_nxt        = w_pc_inc;
            end
         end
         S_DROP: begin
            if (i_branch_en) w_pc_nxt = i_branch_addr;
            if (i_ce_dec)    w_state_nxt = S_REQ;
         end
         S_HOLD: begin
            if (i_branch_en) begin
               w_pc_nxt        = i_branch_addr;
               w_valid_nxt     = 1'b0;
               w_halt_pend_nxt = 1'b0;
               w_state_nxt     = S_REQ;
            end else if (i_dec_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = r_halt_pend ? S_HALT : S_REQ;
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_REQ;
         r_pc        <= P_RESET_PC;
         r_instr     <= 16'h0000;
         r_instr_pc  <= 16'h0000;
         r_valid     <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_instr     <= w_instr_nxt;
         r_instr_pc  <= w_instr_pc_nxt;
         r_valid     <= w_valid_nxt;
         r_halt_pend <= w_halt_pend_nxt;
      end
   end

   assign q_ce_fetch    = w_ce_fetch;
   assign q_mem_addr    = r_pc;
   assign q_instr       = r_instr;
   assign q_instr_pc    = r_instr_pc;
   assign q_instr_valid = r_valid;

endmodule

// File: doc/prco_fetch.md
PRCO_FETCH -- requirements
Module: prco_fetch

Interface
REQ-001 Parameter P_RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter P_PC_MAX, default 16'h00FF: highest fetchable address; PC wraps to 16'h0000 after it.
REQ-003 i_clk  in  1  sole clock; all state updates on posedge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_mem_busy  in  1  ALU owns the local-memory port this cycle; fetch shall not request.
REQ-006 i_ce_dec  in  1  one-cycle pulse from local memory: i_mem_douta holds fetched word.
REQ-007 i_mem_douta  in  16  instruction word from local memory.
REQ-008 i_dec_ready  in  1  decode stage accepts q_instr this cycle.
REQ-009 i_branch_en  in  1  redirect request, one-cycle pulse.
REQ-010 i_branch_addr  in  16  redirect target, sampled when i_branch_en=1.
REQ-011 q_ce_fetch  out  1  fetch enable to local memory, one-cycle pulse.
REQ-012 q_mem_addr  out  16  fetch address (current PC).
REQ-013 q_instr  out  16  captured instruction.
REQ-014 q_instr_pc  out  16  address q_instr was fetched from.
REQ-015 q_instr_valid  out  1  q_instr valid to decode.
REQ-016 q_halted  out  1  fetch stopped on HALT (see Configuration).

Function
REQ-017 FSM states: S_REQ, S_WAIT, S_DROP, S_HOLD, S_HALT.
REQ-018 S_REQ: if i_mem_busy=0, q_ce_fetch=1 for exactly that cycle, q_mem_addr=PC, next S_WAIT; else stay, q_ce_fetch=0.
REQ-019 S_WAIT: on i_ce_dec=1 register i_mem_douta into q_instr, PC into q_instr_pc, set q_instr_valid next cycle, go S_HOLD; else stay.
REQ-020 Latency: q_ce_fetch in cycle N -> i_ce_dec in N+1 -> q_instr_valid=1 from N+2.
REQ-021 PC advances on capture: PC==P_PC_MAX -> 16'h0000, else PC+1 (16-bit).
REQ-022 S_HOLD: q_instr/q_instr_pc stable while q_instr_valid=1 and i_dec_ready=0; on i_dec_ready=1 clear q_instr_valid next cycle, go S_REQ.
REQ-023 q_ce_fetch shall never be asserted in S_WAIT, S_DROP, S_HOLD or S_HALT; at most one outstanding request.
REQ-024 Branch (i_branch_en=1) overrides i_dec_ready and i_ce_dec: PC<=i_branch_addr, q_instr_valid<=0; from S_REQ/S_HOLD -> S_REQ; from S_WAIT without i_ce_dec in same cycle -> S_DROP; from S_WAIT with i_ce_dec same cycle -> S_REQ, word discarded.
REQ-025 S_DROP: discard word on i_ce_dec (no capture, no PC change), go S_REQ.
REQ-026 i_branch_en ignored in S_HALT; i_ce_dec outside S_WAIT/S_DROP ignored.
REQ-027 i_branch_addr > P_PC_MAX is loaded unchanged; wrap applies only at increment.

Reset
REQ-028 i_reset=1 at posedge: PC<=P_RESET_PC, state<=S_REQ, q_ce_fetch=0, q_mem_addr=P_RESET_PC, q_instr=0, q_instr_pc=0, q_instr_valid=0, q_halted=0.
REQ-029 Reset overrides all inputs and aborts any in-flight request; a late i_ce_dec in the cycle after reset is ignored.
REQ-030 First q_ce_fetch possible in the first cycle with i_reset=0.

Configuration
REQ-031 Macro PRCO_FETCH_HALT_EN defined: captured word 16'hFFFF is presented to decode normally, PC not advanced, then after acceptance FSM enters S_HALT, q_halted=1 until reset.
REQ-032 PRCO_FETCH_HALT_EN undefined: 16'hFFFF is an ordinary word, S_HALT unreachable, q_halted tied 0.

Verification
REQ-033 Reset release, memory [0]=16'h20AB, [1]=16'h21CD, i_dec_ready=1 -> q_ce_fetch at cycles 0 and 3, q_instr 20AB (pc 0) then 21CD (pc 1), valid from cycles 2 and 5.
REQ-034 i_mem_busy=1 for 4 cycles in S_REQ -> no q_ce_fetch during them; fetch issued in first cycle busy=0.
REQ-035 i_dec_ready=0 for 5 cycles with word 16'h22EF held -> q_instr stable, valid=1, no new q_ce_fetch.
REQ-036 i_branch_en with i_branch_addr=16'h0010 one cycle after q_ce_fetch to 0 -> fetched word dropped, next q_ce_fetch addr 16'h0010.
REQ-037 PC=16'h00FF, fetch accepted -> next q_mem_addr=16'h0000.
REQ-038 With PRCO_FETCH_HALT_EN, word 16'hFFFF at addr 5 -> delivered once, q_halted=1, no further q_ce_fetch; branch ignored; i_reset restores fetch from 0.
